// File: rtl/apb_ctrl_pkg.sv
// Shared types and constants for the APB master arbiter.
// Holds the FSM state encoding, PSEL one-hot codes and the default memory map.
package apb_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_ACK
    } state_e;

    localparam logic [1:0] PSEL_NONE = 2'b00;
    localparam logic [1:0] PSEL_GPIO = 2'b01;
    localparam logic [1:0] PSEL_UART = 2'b10;

    localparam logic [31:0] DEF_GPIO_BASE   = 32'h0000_0000;
    localparam logic [31:0] DEF_UART_BASE   = 32'h0000_1000;
    localparam logic [31:0] DEF_REGION_MASK = 32'hFFFF_F000;

    function automatic logic [1:0] decode_psel(
        input logic [31:0] addr,
        input logic [31:0] mask,
        input logic [31:0] gpio_base,
        input logic [31:0] uart_base
    );
        if ((addr & mask) == gpio_base) return PSEL_GPIO;
        if ((addr & mask) == uart_base) return PSEL_UART;
        return PSEL_NONE;
    endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// APB bus bundle between the master arbiter and the peripheral slaves.
// The master modport drives address/control; the slave modport answers.
interface apb_master_arbiter_if;

    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic [1:0]  PSEL;
    logic        PENABLE;
    logic [2:0]  PPROT;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE, PPROT,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE, PPROT,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin arbiter with a registered last-grant pointer.
// last_o also names the current owner while a transfer is in flight.
module apb_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic [1:0] gnt_o,
    output logic       last_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_d = last_q;
        if (adv_i && (|req_i)) begin
            last_d = gnt_o[1];
        end
    end

    // Reset to requester 1 so requester 0 wins the first contention.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_o = last_q;

endmodule

// File: rtl/apb_master_arbiter.sv
// Sole APB master: round-robin between two requesters, address decode,
// SETUP/ACCESS sequencing and a PREADY timeout.
module apb_master_arbiter
    import apb_ctrl_pkg::*;
#(
    parameter logic [31:0] GPIO_BASE      = DEF_GPIO_BASE,
    parameter logic [31:0] UART_BASE      = DEF_UART_BASE,
    parameter logic [31:0] REGION_MASK    = DEF_REGION_MASK,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [2:0]  P0_PROT        = 3'b001,
    parameter logic [2:0]  P1_PROT        = 3'b000
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        req0_ack,
    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        req1_ack,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    apb_master_arbiter_if.master apb
);

    state_e      state_q;
    logic [31:0] wait_q;
    logic [31:0] paddr_q;
    logic [31:0] pwdata_q;
    logic        pwrite_q;
    logic [1:0]  psel_q;
    logic        penable_q;
    logic [2:0]  pprot_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        ack0_q;
    logic        ack1_q;
    logic        busy_q;

    logic [1:0]  gnt;
    logic        owner;
    logic        adv;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_write;
    logic [1:0]  sel_psel;
    logic        timed_out;

    assign adv = (state_q == ST_IDLE) && (req0_valid || req1_valid);

    apb_rr_arb2 u_arb (
        .clk_i  (PCLK),
        .rst_i  (PRESET),
        .req_i  ({req1_valid, req0_valid}),
        .adv_i  (adv),
        .gnt_o  (gnt),
        .last_o (owner)
    );

    assign sel_addr  = gnt[1] ? req1_addr  : req0_addr;
    assign sel_wdata = gnt[1] ? req1_wdata : req0_wdata;
    assign sel_write = gnt[1] ? req1_write : req0_write;
    assign sel_psel  = decode_psel(sel_addr, REGION_MASK,
                                   GPIO_BASE, UART_BASE);

    // wait_q counts stalled ACCESS cycles already seen.
    assign timed_out = (TIMEOUT_CYCLES != 0) &&
                       ((wait_q + 32'd1) == TIMEOUT_CYCLES);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= ST_IDLE;
            wait_q    <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= PSEL_NONE;
            penable_q <= 1'b0;
            pprot_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (adv) begin
                        paddr_q  <= sel_addr;
                        pwdata_q <= sel_wdata;
                        pwrite_q <= sel_write;
                        pprot_q  <= gnt[1] ? P1_PROT : P0_PROT;
                        wait_q   <= '0;
                        busy_q   <= 1'b1;
                        if (sel_psel != PSEL_NONE) begin
                            psel_q    <= sel_psel;
                            penable_q <= 1'b0;
                            state_q   <= ST_SETUP;
                        end else begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                            ack0_q  <= gnt[0];
                            ack1_q  <= gnt[1];
                            state_q <= ST_ACK;
                        end
                    end
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (apb.PREADY) begin
                        rdata_q   <= pwrite_q ? '0 : apb.PRDATA;
                        err_q     <= apb.PSLVERR;
                        psel_q    <= PSEL_NONE;
                        penable_q <= 1'b0;
                        ack0_q    <= ~owner;
                        ack1_q    <= owner;
                        state_q   <= ST_ACK;
                    end else if (timed_out) begin
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                        psel_q    <= PSEL_NONE;
                        penable_q <= 1'b0;
                        ack0_q    <= ~owner;
                        ack1_q    <= owner;
                        state_q   <= ST_ACK;
                    end else begin
                        wait_q <= wait_q + 32'd1;
                    end
                end
                ST_ACK: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign apb.PADDR   = paddr_q;
    assign apb.PWDATA  = pwdata_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PSEL    = psel_q;
    assign apb.PENABLE = penable_q;
    assign apb.PPROT   = pprot_q;
    assign req0_ack    = ack0_q;
    assign req1_ack    = ack1_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: per-scenario tasks plus
// an ack monitor that pops expected responses from a scoreboard queue.
module tb_apb_master_arbiter;

    logic        PCLK;
    logic        PRESET;
    logic        req0_valid, req0_write, req0_ack;
    logic [31:0] req0_addr, req0_wdata;
    logic        req1_valid, req1_write, req1_ack;
    logic [31:0] req1_addr, req1_wdata;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    apb_master_arbiter_if apb ();

    apb_master_arbiter #(
        .GPIO_BASE      (32'h0000_0000),
        .UART_BASE      (32'h0000_1000),
        .REGION_MASK    (32'hFFFF_F000),
        .TIMEOUT_CYCLES (16),
        .P0_PROT        (3'b001),
        .P1_PROT        (3'b000)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .req0_valid (req0_valid),
        .req0_write (req0_write),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_ack   (req0_ack),
        .req1_valid (req1_valid),
        .req1_write (req1_write),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_ack   (req1_ack),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .apb        (apb)
    );

    typedef struct packed {
        logic        id;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Ack monitor: every ack must match the oldest expected response.
    always begin
        exp_t e;
        @(posedge PCLK);
        #1;
        if (req0_ack && req1_ack) begin
            checks++;
            errors++;
            $display("FAIL dual_ack: both acks high at %0t", $time);
        end else if (req0_ack || req1_ack) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: id=%0d with empty scoreboard",
                         req1_ack);
            end else begin
                e = sb.pop_front();
                if ({req1_ack, rsp_rdata, rsp_err} !== {e.id, e.rdata, e.err}) begin
                    errors++;
                    $display("FAIL sb_rsp: got id=%0d rdata=%h err=%0d, want id=%0d rdata=%h err=%0d",
                             req1_ack, rsp_rdata, rsp_err, e.id, e.rdata, e.err);
                end
            end
        end
    end

    task automatic wait_ack(input logic id, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (id ? req1_ack : req0_ack) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        tick();
        tick();
        checks++;
        if ({req0_ack, req1_ack, rsp_rdata, rsp_err, busy, apb.PADDR, apb.PWDATA,
             apb.PWRITE, apb.PSEL, apb.PENABLE, apb.PPROT} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: some output nonzero (busy=%0d psel=%b paddr=%h)",
                     busy, apb.PSEL, apb.PADDR);
        end
        PRESET = 1'b0;
        tick();
    endtask

    task automatic test_write_basic();
        apb.PREADY = 1'b1;
        sb.push_back('{id: 1'b0, rdata: 32'h0, err: 1'b0});
        req0_write = 1'b1;
        req0_addr  = 32'h0000_0004;
        req0_wdata = 32'h0000_00A5;
        req0_valid = 1'b1;
        tick();
        checks++;
        if ({apb.PSEL, apb.PENABLE, apb.PADDR, apb.PWDATA, apb.PWRITE, apb.PPROT} !==
            {2'b01, 1'b0, 32'h4, 32'hA5, 1'b1, 3'b001}) begin
            errors++;
            $display("FAIL wr_setup: psel=%b pen=%0d paddr=%h pwdata=%h pwrite=%0d pprot=%b, want 01 0 4 a5 1 001",
                     apb.PSEL, apb.PENABLE, apb.PADDR, apb.PWDATA, apb.PWRITE, apb.PPROT);
        end
        tick();
        checks++;
        if ({apb.PSEL, apb.PENABLE} !== 3'b011) begin
            errors++;
            $display("FAIL wr_access: psel=%b pen=%0d, want 01 1", apb.PSEL, apb.PENABLE);
        end
        tick();
        checks++;
        if ({req0_ack, rsp_err, apb.PSEL, apb.PENABLE} !== 5'b10000) begin
            errors++;
            $display("FAIL wr_ack_T3: ack=%0d err=%0d psel=%b pen=%0d, want 1 0 00 0",
                     req0_ack, rsp_err, apb.PSEL, apb.PENABLE);
        end
        req0_valid = 1'b0;
        tick();
        checks++;
        if ({busy, req0_ack} !== 2'b00) begin
            errors++;
            $display("FAIL wr_idle_T4: busy=%0d ack=%0d, want 0 0", busy, req0_ack);
        end
    endtask

    task automatic test_wait_read();
        bit ok;
        apb.PREADY = 1'b0;
        apb.PRDATA = 32'h0;
        sb.push_back('{id: 1'b1, rdata: 32'h55, err: 1'b0});
        req1_write = 1'b0;
        req1_addr  = 32'h0000_1008;
        req1_valid = 1'b1;
        tick();
        checks++;
        if ({apb.PSEL, apb.PPROT, apb.PWRITE} !== {2'b10, 3'b000, 1'b0}) begin
            errors++;
            $display("FAIL rd_setup: psel=%b pprot=%b pwrite=%0d, want 10 000 0",
                     apb.PSEL, apb.PPROT, apb.PWRITE);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({apb.PSEL, apb.PENABLE, apb.PADDR} !== {2'b10, 1'b1, 32'h1008}) begin
                errors++;
                $display("FAIL rd_wait%0d: psel=%b pen=%0d paddr=%h, want 10 1 1008",
                         i, apb.PSEL, apb.PENABLE, apb.PADDR);
            end
            tick();
        end
        apb.PREADY = 1'b1;
        apb.PRDATA = 32'h55;
        wait_ack(1'b1, 4, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rd_ack_timeout: req1_ack=%0d, want 1", req1_ack);
        end
        req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        int n;
        apb.PREADY = 1'b1;
        apb.PRDATA = 32'h77;
        req0_write = 1'b0;
        req0_addr  = 32'h0000_0000;
        req1_write = 1'b0;
        req1_addr  = 32'h0000_1000;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{id: logic'(i % 2), rdata: 32'h77, err: 1'b0});
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            tick();
            if (req0_ack || req1_ack) begin
                checks++;
                if (req1_ack !== logic'(n % 2)) begin
                    errors++;
                    $display("FAIL rr_order%0d: granted id=%0d, want %0d", n, req1_ack, n % 2);
                end
                n++;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL rr_count: acks=%0d, want 4", n);
        end
        tick();
    endtask

    task automatic test_unmapped();
        sb.push_back('{id: 1'b0, rdata: 32'h0, err: 1'b1});
        apb.PRDATA = 32'hDEAD_BEEF;
        req0_write = 1'b0;
        req0_addr  = 32'h0000_8000;
        req0_valid = 1'b1;
        tick();
        checks++;
        if ({req0_ack, rsp_err, rsp_rdata, apb.PSEL} !== {1'b1, 1'b1, 32'h0, 2'b00}) begin
            errors++;
            $display("FAIL unmapped_ack: ack=%0d err=%0d rdata=%h psel=%b, want 1 1 0 00",
                     req0_ack, rsp_err, rsp_rdata, apb.PSEL);
        end
        req0_valid = 1'b0;
        tick();
        checks++;
        if ({apb.PSEL, busy} !== 3'b000) begin
            errors++;
            $display("FAIL unmapped_idle: psel=%b busy=%0d, want 00 0", apb.PSEL, busy);
        end
    endtask

    task automatic test_timeout();
        int n;
        apb.PREADY = 1'b0;
        sb.push_back('{id: 1'b0, rdata: 32'h0, err: 1'b1});
        req0_write = 1'b0;
        req0_addr  = 32'h0000_0010;
        req0_valid = 1'b1;
        tick();
        tick();
        n = 0;
        while (apb.PENABLE && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL timeout_len: access cycles=%0d, want 16", n);
        end
        checks++;
        if ({req0_ack, rsp_err, apb.PSEL, apb.PENABLE} !== 5'b11000) begin
            errors++;
            $display("FAIL timeout_abort: ack=%0d err=%0d psel=%b pen=%0d, want 1 1 00 0",
                     req0_ack, rsp_err, apb.PSEL, apb.PENABLE);
        end
        req0_valid = 1'b0;
        tick();
    endtask

    task automatic test_slverr();
        bit ok;
        apb.PREADY  = 1'b1;
        apb.PSLVERR = 1'b1;
        apb.PRDATA  = 32'hDEAD_0001;
        sb.push_back('{id: 1'b1, rdata: 32'h0, err: 1'b1});
        req1_write = 1'b1;
        req1_addr  = 32'h0000_1004;
        req1_wdata = 32'h99;
        req1_valid = 1'b1;
        wait_ack(1'b1, 8, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL slverr_ack_timeout: req1_ack=%0d, want 1", req1_ack);
        end
        req1_valid  = 1'b0;
        apb.PSLVERR = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        apb.PREADY = 1'b0;
        apb.PRDATA = 32'h0000_0ABC;
        req0_write = 1'b0;
        req0_addr  = 32'h0000_0020;
        req0_valid = 1'b1;
        tick();
        tick();
        tick();
        PRESET = 1'b1;
        req1_write = 1'b0;
        req1_addr  = 32'h0000_1000;
        req1_valid = 1'b1;
        tick();
        checks++;
        if ({req0_ack, req1_ack, rsp_rdata, rsp_err, busy, apb.PADDR, apb.PWDATA,
             apb.PWRITE, apb.PSEL, apb.PENABLE, apb.PPROT} !== '0) begin
            errors++;
            $display("FAIL reset_mid: outputs nonzero (busy=%0d psel=%b pen=%0d ack0=%0d)",
                     busy, apb.PSEL, apb.PENABLE, req0_ack);
        end
        tick();
        PRESET = 1'b0;
        apb.PREADY = 1'b1;
        sb.push_back('{id: 1'b0, rdata: 32'h0ABC, err: 1'b0});
        sb.push_back('{id: 1'b1, rdata: 32'h0ABC, err: 1'b0});
        tick();
        checks++;
        if (apb.PSEL !== 2'b01) begin
            errors++;
            $display("FAIL reset_regrant: psel=%b, want 01", apb.PSEL);
        end
        wait_ack(1'b0, 8, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_req0_ack_timeout: req0_ack=%0d, want 1", req0_ack);
        end
        req0_valid = 1'b0;
        wait_ack(1'b1, 8, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_req1_ack_timeout: req1_ack=%0d, want 1", req1_ack);
        end
        req1_valid = 1'b0;
        tick();
    endtask

    initial begin
        PRESET      = 1'b1;
        req0_valid  = 1'b0;
        req0_write  = 1'b0;
        req0_addr   = '0;
        req0_wdata  = '0;
        req1_valid  = 1'b0;
        req1_write  = 1'b0;
        req1_addr   = '0;
        req1_wdata  = '0;
        apb.PRDATA  = '0;
        apb.PREADY  = 1'b0;
        apb.PSLVERR = 1'b0;
        test_reset();
        test_write_basic();
        test_wait_read();
        test_round_robin();
        test_unmapped();
        test_timeout();
        test_slverr();
        test_reset_mid();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d responses never acked, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Sole APB master for the GPIO/UART peripheral bus.
- Accepts transfer requests from two on-chip requesters and arbitrates between them round-robin.
- Decodes the address to a one-hot PSEL (bit0 = GPIO, bit1 = UART) and sequences APB SETUP/ACCESS phases.
- Returns read data and error status to the winning requester, with a PREADY timeout so a hung slave cannot stall the bus.

Parameters:
- GPIO_BASE, 32'h0000_0000, base address of the GPIO region.
- UART_BASE, 32'h0000_1000, base address of the UART region.
- REGION_MASK, 32'hFFFF_F000, mask applied to the address before comparing against the bases.
- TIMEOUT_CYCLES, 16, ACCESS cycles with PREADY=0 before abort; 0 disables the timeout.
- P0_PROT, 3'b001, PPROT driven for requester 0.
- P1_PROT, 3'b000, PPROT driven for requester 1.

Ports:
- PCLK in 1: single clock.
- PRESET in 1: synchronous, active-high reset.
- req0_valid in 1: requester 0 request; held until req0_ack.
- req0_write in 1: 1 = write, 0 = read.
- req0_addr in 32: byte address.
- req0_wdata in 32: write data.
- req0_ack out 1: one-cycle completion pulse.
- req1_valid, req1_write, req1_addr, req1_wdata, req1_ack: same as requester 0, for requester 1.
- rsp_rdata out 32: read data, valid only while an ack is high.
- rsp_err out 1: error flag, valid only while an ack is high.
- busy out 1: high in any state other than IDLE.
- PADDR out 32, PWDATA out 32, PWRITE out 1, PSEL out 2, PENABLE out 1, PPROT out 3: APB master outputs.
- PRDATA in 32, PREADY in 1, PSLVERR in 1: APB slave responses.

Behaviour:
- Reset:
  - On PRESET, all outputs go to 0 on the next PCLK edge, state goes to IDLE and the round-robin pointer is set so requester 0 wins first.
  - A reset mid-transfer aborts the transfer without issuing an ack; requesters must re-issue.
- States: IDLE, SETUP, ACCESS, ACK.
- IDLE:
  - If any valid is high, grant one requester.
    - One valid high: grant it.
    - Both high: grant the requester not granted last.
    - Update the pointer on every grant.
  - Register PADDR, PWDATA and PWRITE from the granted requester. Set PPROT to that requester's parameter.
  - Decode the masked address:
    - Match GPIO_BASE: PSEL=2'b01.
    - Match UART_BASE: PSEL=2'b10.
  - Mapped address: PSEL asserted, PENABLE=0, next state SETUP.
  - Unmapped address: PSEL stays 0, next state ACK with rsp_err=1 and rsp_rdata=0.
- SETUP: lasts exactly 1 cycle; PENABLE goes to 1; next state ACCESS.
- ACCESS:
  - PREADY=1: capture PRDATA (reads only, else 0) and PSLVERR into rsp_rdata/rsp_err, drop PSEL and PENABLE, next state ACK.
  - PREADY=0: increment the wait counter. When it equals TIMEOUT_CYCLES (non-zero), drop PSEL and PENABLE, set rsp_err=1 and rsp_rdata=0, next state ACK.
- ACK:
  - Assert the granted requester's ack for exactly 1 cycle; the other ack stays 0; next state IDLE.
  - rsp_rdata and rsp_err are held until the next ACK.
  - A requester that still holds valid in the following IDLE cycle is treated as a new request.
- Timing:
  - Minimum latency is 4 cycles from IDLE sampling valid to the ack pulse (IDLE, SETUP, ACCESS, ACK).
  - An unmapped address acks in 2 cycles.
- Bus rules:
  - PADDR, PWDATA, PWRITE and PPROT are stable from SETUP through the last ACCESS cycle and hold their values in IDLE/ACK.
  - At most one PSEL bit is ever set.
  - PENABLE=1 only in ACCESS.
- Request fields changing while valid is high and before the ack is a protocol violation and need not be handled.

Decomposition:
- Package apb_ctrl_pkg holds:
  - the state enum;
  - PSEL one-hot constants PSEL_GPIO=2'b01, PSEL_UART=2'b10, PSEL_NONE=2'b00;
  - default base and mask constants.
- Sub-module apb_rr_arb2: 2-way round-robin arbiter.
  - Inputs: two request bits, an advance strobe.
  - Outputs: one-hot grant, last-grant pointer.
- The FSM, address decode and timeout counter stay in apb_master_arbiter.

Test Plan:
- req0 write addr 0x0000_0004 data 0xA5, PREADY tied 1:
  - Response: PSEL=01 SETUP at T1, PENABLE=1 at T2, req0_ack with rsp_err=0 at T3, busy low at T4.
- req1 read addr 0x0000_1008, PREADY low 3 ACCESS cycles, then high with PRDATA=0x55:
  - Response: PSEL=10 throughout; PADDR stable through all ACCESS cycles; req1_ack with rsp_rdata=0x55.
- req0 and req1 held valid continuously for 4 transfers:
  - Response: grants in order 0,1,0,1; never two acks in one cycle.
- req0 read addr 0x0000_8000 (unmapped):
  - Response: PSEL never asserted; req0_ack 2 cycles later with rsp_err=1 and rsp_rdata=0.
- GPIO read with PREADY held 0 and TIMEOUT_CYCLES=16:
  - Response: PSEL and PENABLE drop after 16 ACCESS cycles; ack with rsp_err=1.
  - Follow-up: a PSLVERR=1 completion likewise sets rsp_err=1.
- PRESET asserted during ACCESS:
  - Response: next cycle all outputs 0 and state IDLE; no ack issued.
  - After reset release, a pending req0 is re-granted first.
